wwjump_sprite_fetch: RTL and testbench

WWJUMP_SPRITE_FETCH -- requirements
Module: wwjump_sprite_fetch

---
 rtl/wwjump_sprite_fetch.sv | 130 +++++++++++++
 tb/tb_wwjump_sprite_fetch.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wwjump_sprite_fetch.sv
// Jump-animation sprite fetcher: a frame/hold sequencer plus a 3-stage hit-test -> ROM -> palette-index pipeline.
// Latency 3 Clk from DrawX/DrawY to pix_index/pix_valid, one pixel per cycle; no backpressure, never stalls.
module wwjump_sprite_fetch #(
    parameter int SPR_W      = 64,
    parameter int SPR_H      = 96,
    parameter int NUM_FRAMES = 4,
    parameter int HOLD_TICKS = 6,
    parameter int ADDR_W     = 15,
    localparam int FN_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              vsync_tick,
    input  logic              jump_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        SprX,
    input  logic [9:0]        SprY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pix_index,
    output logic              pix_valid,
    output logic              busy,
    output logic [FN_W-1:0]   frame_num
);

    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [FN_W-1:0]   FRAME_LAST = FN_W'(NUM_FRAMES - 1);
    localparam logic [ADDR_W-1:0] FRAME_SZ   = ADDR_W'(SPR_W * SPR_H);
    localparam logic [ADDR_W-1:0] ROW_SZ     = ADDR_W'(SPR_W);
    localparam logic [10:0]       SPR_W11    = 11'(SPR_W);
    localparam logic [10:0]       SPR_H11    = 11'(SPR_H);

    typedef enum logic {IDLE, JUMP} state_t;

    state_t              state_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [FN_W-1:0]     frame_q;
    logic                busy_q;

    // Frame and hold only move on a vsync tick, so a displayed frame never tears.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            frame_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (jump_start) begin
                        state_q <= JUMP;
                        busy_q  <= 1'b1;
                        hold_q  <= '0;
                        frame_q <= '0;
                    end
                end
                JUMP: begin
                    if (vsync_tick) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_q <= '0;
                            if (frame_q == FRAME_LAST) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                frame_q <= '0;
                            end else begin
                                frame_q <= frame_q + FN_W'(1);
                            end
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Hit test is widened to 11 bits so a sprite hanging off the right/bottom edge does not wrap.
    logic [10:0]       x_end, y_end;
    logic [9:0]        rel_x, rel_y;
    logic              in_spr_d;
    logic [ADDR_W-1:0] rom_addr_d;

    always_comb begin
        x_end      = {1'b0, SprX} + SPR_W11;
        y_end      = {1'b0, SprY} + SPR_H11;
        rel_x      = DrawX - SprX;
        rel_y      = DrawY - SprY;
        in_spr_d   = ({1'b0, DrawX} >= {1'b0, SprX}) && ({1'b0, DrawX} < x_end) &&
                     ({1'b0, DrawY} >= {1'b0, SprY}) && ({1'b0, DrawY} < y_end);
        rom_addr_d = '0;
        if (in_spr_d) begin
            rom_addr_d = ADDR_W'(frame_q) * FRAME_SZ + ADDR_W'(rel_y) * ROW_SZ + ADDR_W'(rel_x);
        end
    end

    logic [ADDR_W-1:0] rom_addr_q;
    logic              in_spr1_q, in_spr2_q;
    logic [3:0]        pix_index_q;
    logic              pix_valid_q;

    // in_spr2_q lines up with rom_data, which the ROM returns one cycle after rom_addr.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr_q  <= '0;
            in_spr1_q   <= 1'b0;
            in_spr2_q   <= 1'b0;
            pix_index_q <= 4'd0;
            pix_valid_q <= 1'b0;
        end else begin
            rom_addr_q  <= rom_addr_d;
            in_spr1_q   <= in_spr_d;
            in_spr2_q   <= in_spr1_q;
            pix_index_q <= in_spr2_q ? rom_data : 4'd0;
            pix_valid_q <= in_spr2_q && (rom_data != 4'd0);
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pix_index = pix_index_q;
    assign pix_valid = pix_valid_q;
    assign busy      = busy_q;
    assign frame_num = frame_q;

endmodule

// File: tb/tb_wwjump_sprite_fetch.sv
// Directed bench for wwjump_sprite_fetch; the sprite ROM is modelled here as data = (addr[3:0] + 5) mod 16.
module tb_wwjump_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        vsync_tick = 1'b0;
    logic        jump_start = 1'b0;
    logic [9:0]  DrawX = 10'd0, DrawY = 10'd0, SprX = 10'd100, SprY = 10'd50;
    logic [14:0] rom_addr;
    logic [3:0]  rom_data = 4'd0;
    logic [3:0]  pix_index;
    logic        pix_valid;
    logic        busy;
    logic [1:0]  frame_num;

    int tests = 0;
    int fails = 0;

    wwjump_sprite_fetch dut (
        .Clk(Clk), .Reset(Reset), .vsync_tick(vsync_tick), .jump_start(jump_start),
        .DrawX(DrawX), .DrawY(DrawY), .SprX(SprX), .SprY(SprY),
        .rom_addr(rom_addr), .rom_data(rom_data), .pix_index(pix_index),
        .pix_valid(pix_valid), .busy(busy), .frame_num(frame_num)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= rom_addr[3:0] + 4'd5;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    // 24 vsync ticks with a quiet cycle after each; optional mid-jump jump_start and frame-2 address probe.
    task automatic run_jump(input int inject_at, input bit probe);
        for (int k = 1; k <= 24; k++) begin
            vsync_tick = 1'b1;
            tick();
            vsync_tick = 1'b0;
            check("frame_num_tick", 32'(frame_num), (k < 24) ? 32'(k / 6) : 32'd0);
            check("busy_tick", 32'(busy), (k < 24) ? 32'd1 : 32'd0);
            if (k == inject_at) jump_start = 1'b1;
            if (probe && k == 12) begin
                DrawX = 10'd100;
                DrawY = 10'd50;
            end
            tick();
            jump_start = 1'b0;
            if (probe && k == 12) check("rom_addr_frame2", 32'(rom_addr), 32'd12288);
            DrawX = 10'd0;
            check("frame_num_hold", 32'(frame_num), (k < 24) ? 32'(k / 6) : 32'd0);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        Reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame", 32'(frame_num), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_pix_index", 32'(pix_index), 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);

        // Top-left pixel: address 0, ROM data 5, exactly 3 cycles of latency
        DrawX = 10'd100; DrawY = 10'd50;
        tick();
        check("tl_addr", 32'(rom_addr), 32'd0);
        DrawX = 10'd0;
        tick();
        check("tl_valid_early", 32'(pix_valid), 32'd0);
        tick();
        check("tl_index", 32'(pix_index), 32'd5);
        check("tl_valid", 32'(pix_valid), 32'd1);
        tick();
        check("tl_after_valid", 32'(pix_valid), 32'd0);

        // Bottom-right pixel, then one past the right edge
        DrawX = 10'd163; DrawY = 10'd145;
        tick();
        check("br_addr", 32'(rom_addr), 32'd6143);
        DrawX = 10'd164;
        tick();
        check("edge_addr", 32'(rom_addr), 32'd0);
        tick();
        check("br_index", 32'(pix_index), 32'd4);
        check("br_valid", 32'(pix_valid), 32'd1);
        tick();
        check("edge_index", 32'(pix_index), 32'd0);
        check("edge_valid", 32'(pix_valid), 32'd0);

        // Transparent index inside the sprite, then an opaque neighbour
        DrawX = 10'd111; DrawY = 10'd50;
        tick();
        check("transp_addr", 32'(rom_addr), 32'd11);
        DrawX = 10'd112;
        tick();
        tick();
        check("transp_index", 32'(pix_index), 32'd0);
        check("transp_valid", 32'(pix_valid), 32'd0);
        tick();
        check("opaque_index", 32'(pix_index), 32'd1);
        check("opaque_valid", 32'(pix_valid), 32'd1);

        // Sprite hanging off the right edge: no wrap-around hits
        SprX = 10'd1000; DrawX = 10'd1023; DrawY = 10'd50;
        tick();
        check("offscr_addr", 32'(rom_addr), 32'd23);
        DrawX = 10'd5;
        tick();
        check("offscr_wrap_addr", 32'(rom_addr), 32'd0);
        tick();
        check("offscr_index", 32'(pix_index), 32'd12);
        tick();
        check("offscr_wrap_valid", 32'(pix_valid), 32'd0);
        SprX = 10'd100; DrawX = 10'd0;

        // Full jump animation
        jump_start = 1'b1;
        tick();
        jump_start = 1'b0;
        check("jump_busy", 32'(busy), 32'd1);
        check("jump_frame", 32'(frame_num), 32'd0);
        run_jump(-1, 1'b1);

        // Entry tick not counted, and a mid-jump jump_start does not restart
        jump_start = 1'b1; vsync_tick = 1'b1;
        tick();
        jump_start = 1'b0; vsync_tick = 1'b0;
        check("coinc_busy", 32'(busy), 32'd1);
        check("coinc_frame", 32'(frame_num), 32'd0);
        run_jump(9, 1'b0);

        // Reset at frame 2 with jump_start and vsync in the same cycle
        jump_start = 1'b1;
        tick();
        jump_start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            vsync_tick = 1'b1;
            tick();
            vsync_tick = 1'b0;
        end
        check("pre_rst_frame", 32'(frame_num), 32'd2);
        DrawX = 10'd100; DrawY = 10'd50;
        tick();
        tick();
        tick();
        check("pre_rst_valid", 32'(pix_valid), 32'd1);
        Reset = 1'b1; jump_start = 1'b1; vsync_tick = 1'b1;
        tick();
        Reset = 1'b0; jump_start = 1'b0; vsync_tick = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_frame", 32'(frame_num), 32'd0);
        check("mid_rst_addr", 32'(rom_addr), 32'd0);
        check("mid_rst_index", 32'(pix_index), 32'd0);
        check("mid_rst_valid", 32'(pix_valid), 32'd0);
        tick();
        check("post_rst_addr", 32'(rom_addr), 32'd0);
        check("post_rst_valid1", 32'(pix_valid), 32'd0);
        tick();
        check("post_rst_valid2", 32'(pix_valid), 32'd0);
        tick();
        check("post_rst_valid3", 32'(pix_valid), 32'd1);
        check("post_rst_index3", 32'(pix_index), 32'd5);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
